// File: rtl/stroke_phase_detector_pkg.sv
// Shared definitions for the stroke phase detector.
// Holds the phase and direction encodings used by the top level, the
// output widths shared with the bus interface, and a width helper used to
// size small saturating counters.
package stroke_phase_detector_pkg;

  typedef enum logic [1:0] {
    PH_IDLE     = 2'd0,
    PH_DRIVE    = 2'd1,
    PH_RECOVERY = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_ACCEL = 2'd1,
    DIR_DECEL = 2'd2
  } dir_e;

  localparam int PHASE_W  = 2;
  localparam int STROKE_W = 16;

  // Bits needed to hold values 0..(n-1); never narrower than one bit.
  function automatic int width_for(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/stroke_phase_detector_if.sv
// Bus between the flywheel sensor side and the stroke counter side.
//   sensor_in      raw asynchronous reed/magnet sensor
//   start_drive    one-cycle pulse on entry to DRIVE
//   start_recovery one-cycle pulse on entry to RECOVERY
//   phase          current phase (IDLE/DRIVE/RECOVERY)
//   period         last captured edge-to-edge period in cycles
//   period_valid   one-cycle pulse when period updates
//   stroke_count   number of start_drive pulses, wrapping at 16 bits
// master: the environment (drives the sensor, consumes results).
// slave : the detector.
interface stroke_phase_detector_if
  import stroke_phase_detector_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  logic                sensor_in;
  logic                start_drive;
  logic                start_recovery;
  logic [PHASE_W-1:0]  phase;
  logic [CNT_W-1:0]    period;
  logic                period_valid;
  logic [STROKE_W-1:0] stroke_count;

  modport master (
    output sensor_in,
    input  start_drive,
    input  start_recovery,
    input  phase,
    input  period,
    input  period_valid,
    input  stroke_count
  );

  modport slave (
    input  sensor_in,
    output start_drive,
    output start_recovery,
    output phase,
    output period,
    output period_valid,
    output stroke_count
  );

endinterface

// File: rtl/stroke_phase_detector_sensor_debounce.sv
// Conditioning for a slow mechanical contact input.
// A 2-flop synchronizer feeds a debounce counter: the accepted level only
// flips after DEBOUNCE consecutive synchronized samples disagree with it.
// rise_o is a registered one-cycle strobe asserted in the cycle the
// accepted level goes 0->1.
//   clk, reset : clock and synchronous active-high reset
//   raw_in     : asynchronous raw contact
//   rise_o     : one-cycle strobe on an accepted rising transition
module stroke_phase_detector_sensor_debounce
  import stroke_phase_detector_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic rise_o
);

  localparam int            CW     = width_for(DEBOUNCE);
  localparam logic [CW-1:0] LAST_C = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          rise_q,  rise_d;

  // Synchronizer shift, debounce counting and rising-edge detection.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = ZERO_C;
    if (sync2_q != level_q) begin
      // cnt_q counts disagreeing samples already seen; this one is the next.
      if (cnt_q == LAST_C) begin
        level_d = sync2_q;
        cnt_d   = ZERO_C;
      end else begin
        level_d = level_q;
        cnt_d   = cnt_q + ONE_C;
      end
    end else begin
      level_d = level_q;
      cnt_d   = ZERO_C;
    end
    rise_d = level_d & ~level_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= ZERO_C;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/stroke_phase_detector.sv
// Flywheel stroke phase detector.
// Measures the cycle count between debounced sensor rising edges, classifies
// each period against the previous one as accelerating (drive) or
// decelerating (recovery) with a hysteresis band, and after CONFIRM
// consecutive same-direction classifications changes phase, emitting one
// registered pulse per phase change. A long gap without edges returns to
// IDLE and re-arms the measurement.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of stroke_phase_detector_if (sensor in, results out)
module stroke_phase_detector
  import stroke_phase_detector_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int DEBOUNCE = 16,
  parameter int HYST     = 8,
  parameter int CONFIRM  = 2,
  parameter int TIMEOUT  = 50000000
) (
  input  logic                    clk,
  input  logic                    reset,
  stroke_phase_detector_if.slave  bus
);

  localparam int               SW        = width_for(CONFIRM + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C    = CNT_W'(0);
  localparam logic [CNT_W:0]   HYST_C    = (CNT_W + 1)'(HYST);
  localparam logic [SW-1:0]    CONFIRM_C = SW'(CONFIRM);
  localparam logic [SW-1:0]    S_ONE_C   = SW'(1);
  localparam logic [SW-1:0]    S_ZERO_C  = SW'(0);

  logic                sensor_edge_s;
  logic [CNT_W-1:0]    period_cnt_q,     period_cnt_d;
  logic [CNT_W-1:0]    prev_q,           prev_d;
  logic                have_prev_q,      have_prev_d;
  dir_e                last_dir_q,       last_dir_d;
  logic [SW-1:0]       streak_q,         streak_d;
  logic [CNT_W-1:0]    period_q,         period_d;
  logic                period_valid_q,   period_valid_d;
  phase_e              phase_q,          phase_d;
  logic                start_drive_q,    start_drive_d;
  logic                start_recovery_q, start_recovery_d;
  logic [STROKE_W-1:0] stroke_count_q,   stroke_count_d;
  dir_e                dir_s;
  logic                confirm_s;
  logic                timeout_s;

  // Classify a new period against the previous one. Extended by one bit so
  // adding the dead band can never wrap.
  function automatic dir_e classify(input logic [CNT_W-1:0] cur,
                                    input logic [CNT_W-1:0] prv);
    logic [CNT_W:0] cur_x;
    logic [CNT_W:0] prv_x;
    cur_x = {1'b0, cur};
    prv_x = {1'b0, prv};
    if ((cur_x + HYST_C) < prv_x) begin
      return DIR_ACCEL;
    end else if (cur_x > (prv_x + HYST_C)) begin
      return DIR_DECEL;
    end else begin
      return DIR_NONE;
    end
  endfunction

  stroke_phase_detector_sensor_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_sensor_debounce (
    .clk    (clk),
    .reset  (reset),
    .raw_in (bus.sensor_in),
    .rise_o (sensor_edge_s)
  );

  // Period measurement, classification and streak tracking.
  always_comb begin
    period_cnt_d   = (period_cnt_q >= TIMEOUT_C) ? period_cnt_q : (period_cnt_q + ONE_C);
    prev_d         = prev_q;
    have_prev_d    = have_prev_q;
    last_dir_d     = last_dir_q;
    streak_d       = streak_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    dir_s          = DIR_NONE;
    confirm_s      = 1'b0;
    // An edge in the same cycle wins over the timeout.
    timeout_s      = (!sensor_edge_s) && (period_cnt_q == TIMEOUT_C);

    if (sensor_edge_s) begin
      period_cnt_d = ONE_C;
      if (have_prev_q) begin
        // period_cnt_q is the captured period for this edge.
        period_d       = period_cnt_q;
        period_valid_d = 1'b1;
        prev_d         = period_cnt_q;
        dir_s          = classify(period_cnt_q, prev_q);
        if (dir_s == DIR_NONE) begin
          streak_d   = S_ZERO_C;
          last_dir_d = DIR_NONE;
        end else if (dir_s == last_dir_q) begin
          streak_d   = (streak_q == CONFIRM_C) ? streak_q : (streak_q + S_ONE_C);
          last_dir_d = dir_s;
        end else begin
          streak_d   = S_ONE_C;
          last_dir_d = dir_s;
        end
        confirm_s = (dir_s != DIR_NONE) && (streak_d == CONFIRM_C);
      end else begin
        // First edge after reset or timeout only arms the measurement.
        have_prev_d = 1'b1;
      end
    end else if (timeout_s) begin
      have_prev_d = 1'b0;
      prev_d      = ZERO_C;
      streak_d    = S_ZERO_C;
      last_dir_d  = DIR_NONE;
    end else begin
      have_prev_d = have_prev_q;
    end
  end

  // Phase FSM next-state logic.
  always_comb begin
    phase_d = phase_q;
    if (timeout_s) begin
      phase_d = PH_IDLE;
    end else if (confirm_s) begin
      case (phase_q)
        PH_IDLE: begin
          if (dir_s == DIR_ACCEL) begin
            phase_d = PH_DRIVE;
          end else begin
            phase_d = PH_IDLE;
          end
        end
        PH_DRIVE: begin
          if (dir_s == DIR_DECEL) begin
            phase_d = PH_RECOVERY;
          end else begin
            phase_d = PH_DRIVE;
          end
        end
        PH_RECOVERY: begin
          if (dir_s == DIR_ACCEL) begin
            phase_d = PH_DRIVE;
          end else begin
            phase_d = PH_RECOVERY;
          end
        end
        default: begin
          phase_d = PH_IDLE;
        end
      endcase
    end else begin
      phase_d = phase_q;
    end
  end

  // Phase FSM outputs: a pulse only on an actual entry into a phase.
  always_comb begin
    start_drive_d    = 1'b0;
    start_recovery_d = 1'b0;
    if ((phase_q != PH_DRIVE) && (phase_d == PH_DRIVE)) begin
      start_drive_d = 1'b1;
    end else if ((phase_q == PH_DRIVE) && (phase_d == PH_RECOVERY)) begin
      start_recovery_d = 1'b1;
    end else begin
      start_drive_d    = 1'b0;
      start_recovery_d = 1'b0;
    end
    stroke_count_d = stroke_count_q + {15'd0, start_drive_d};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt_q     <= ZERO_C;
      prev_q           <= ZERO_C;
      have_prev_q      <= 1'b0;
      last_dir_q       <= DIR_NONE;
      streak_q         <= S_ZERO_C;
      period_q         <= ZERO_C;
      period_valid_q   <= 1'b0;
      phase_q          <= PH_IDLE;
      start_drive_q    <= 1'b0;
      start_recovery_q <= 1'b0;
      stroke_count_q   <= 16'd0;
    end else begin
      period_cnt_q     <= period_cnt_d;
      prev_q           <= prev_d;
      have_prev_q      <= have_prev_d;
      last_dir_q       <= last_dir_d;
      streak_q         <= streak_d;
      period_q         <= period_d;
      period_valid_q   <= period_valid_d;
      phase_q          <= phase_d;
      start_drive_q    <= start_drive_d;
      start_recovery_q <= start_recovery_d;
      stroke_count_q   <= stroke_count_d;
    end
  end

  assign bus.start_drive    = start_drive_q;
  assign bus.start_recovery = start_recovery_q;
  assign bus.phase          = phase_q;
  assign bus.period         = period_q;
  assign bus.period_valid   = period_valid_q;
  assign bus.stroke_count   = stroke_count_q;

endmodule

// File: tb/tb_stroke_phase_detector.sv
// Scoreboard bench for stroke_phase_detector (DEBOUNCE=4, HYST=4,
// CONFIRM=2, TIMEOUT=500). Stimulus pushes the expected result of every
// measured period; a negedge monitor pops and compares on period_valid,
// flags stray pulses and overlapping pulses, and compares output snapshots
// requested by the stimulus.
module tb_stroke_phase_detector;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic [31:0] period;
    logic        drv;
    logic        rec;
    logic [1:0]  ph;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [1:0]  ph;
    logic        drv;
    logic        rec;
    logic        pv;
    logic [31:0] period;
    logic [15:0] cnt;
  } snap_t;

  logic clk = 1'b0;
  logic reset;

  exp_t  sb_q[$];
  snap_t snap_q[$];
  string snap_name_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    end_req = 1'b0;

  stroke_phase_detector_if #(.CNT_W(CNT_W)) bus ();

  stroke_phase_detector #(
    .CNT_W    (CNT_W),
    .DEBOUNCE (4),
    .HYST     (4),
    .CONFIRM  (2),
    .TIMEOUT  (500)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int p, input bit d, input bit r, input int ph, input int c);
    exp_t e;
    e.period = 32'(p);
    e.drv    = d;
    e.rec    = r;
    e.ph     = 2'(ph);
    e.cnt    = 16'(c);
    return e;
  endfunction

  function automatic snap_t mks(input int ph, input int p, input int c);
    snap_t s;
    s.ph     = 2'(ph);
    s.drv    = 1'b0;
    s.rec    = 1'b0;
    s.pv     = 1'b0;
    s.period = 32'(p);
    s.cnt    = 16'(c);
    return s;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rise, stay high 10 cycles, stay low so the next rise is gap cycles later.
  task automatic stroke(input int gap);
    bus.sensor_in = 1'b1;
    cyc(10);
    bus.sensor_in = 1'b0;
    cyc(gap - 10);
  endtask

  task automatic snap(input string nm, input snap_t s);
    snap_name_q.push_back(nm);
    snap_q.push_back(s);
  endtask

  // Monitor: all comparisons happen here.
  always @(negedge clk) begin : mon
    exp_t  e;
    snap_t s;
    snap_t a;
    string nm;
    a.ph     = bus.phase;
    a.drv    = bus.start_drive;
    a.rec    = bus.start_recovery;
    a.pv     = bus.period_valid;
    a.period = bus.period;
    a.cnt    = bus.stroke_count;
    if (!reset) begin
      checks++;
      if (a.drv && a.rec) begin
        errors++;
        $display("FAIL pulse_overlap t=%0t actual drive=%0d recovery=%0d required not both", $time, a.drv, a.rec);
      end
      if (a.pv) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_period t=%0t actual period=%0d required no period_valid", $time, a.period);
        end else begin
          e = sb_q.pop_front();
          if (a.period !== e.period || a.drv !== e.drv || a.rec !== e.rec || a.ph !== e.ph || a.cnt !== e.cnt) begin
            errors++;
            $display("FAIL period_event t=%0t actual period=%0d drv=%0d rec=%0d phase=%0d count=%0d required period=%0d drv=%0d rec=%0d phase=%0d count=%0d",
                     $time, a.period, a.drv, a.rec, a.ph, a.cnt, e.period, e.drv, e.rec, e.ph, e.cnt);
          end
        end
      end else if (a.drv || a.rec) begin
        checks++;
        errors++;
        $display("FAIL stray_pulse t=%0t actual drv=%0d rec=%0d required no pulse without period", $time, a.drv, a.rec);
      end
    end
    if (snap_q.size() != 0) begin
      s  = snap_q.pop_front();
      nm = snap_name_q.pop_front();
      checks++;
      if (a !== s) begin
        errors++;
        $display("FAIL %s t=%0t actual phase=%0d drv=%0d rec=%0d pv=%0d period=%0d count=%0d required phase=%0d drv=%0d rec=%0d pv=%0d period=%0d count=%0d",
                 nm, $time, a.ph, a.drv, a.rec, a.pv, a.period, a.cnt, s.ph, s.drv, s.rec, s.pv, s.period, s.cnt);
      end
    end
    if (end_req) begin
      end_req = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL missing_period actual pending=%0d required 0", sb_q.size());
      end
    end
  end

  initial begin
    int   gaps[10];
    exp_t tab[10];
    gaps = '{100, 90, 80, 90, 100, 90, 80, 100, 98, 102};
    // Accelerating run into DRIVE, decelerating into RECOVERY, back to DRIVE,
    // then variations inside the dead band.
    tab[0] = mk(100, 1'b0, 1'b0, 0, 0);
    tab[1] = mk(90,  1'b0, 1'b0, 0, 0);
    tab[2] = mk(80,  1'b1, 1'b0, 1, 1);
    tab[3] = mk(90,  1'b0, 1'b0, 1, 1);
    tab[4] = mk(100, 1'b0, 1'b1, 2, 1);
    tab[5] = mk(90,  1'b0, 1'b0, 2, 1);
    tab[6] = mk(80,  1'b1, 1'b0, 1, 2);
    tab[7] = mk(100, 1'b0, 1'b0, 1, 2);
    tab[8] = mk(98,  1'b0, 1'b0, 1, 2);
    tab[9] = mk(102, 1'b0, 1'b0, 1, 2);

    reset = 1'b1;
    bus.sensor_in = 1'b0;
    cyc(5);
    reset = 1'b0;

    // Quiet sensor after reset.
    cyc(100);
    snap("reset_idle", mks(0, 0, 0));

    // Short glitch must not register; a later mismeasured period would show it.
    bus.sensor_in = 1'b1;
    cyc(3);
    bus.sensor_in = 1'b0;
    cyc(20);

    for (int i = 0; i < 10; i++) begin
      if (i > 0) sb_q.push_back(tab[i-1]);
      stroke(gaps[i]);
    end
    sb_q.push_back(tab[9]);
    bus.sensor_in = 1'b1;
    cyc(10);
    bus.sensor_in = 1'b0;
    cyc(600);
    snap("timeout_idle", mks(0, 102, 2));

    // Re-arm edge, then a measured decel (ignored in IDLE) and two accels.
    stroke(100);
    sb_q.push_back(mk(100, 1'b0, 1'b0, 0, 2));
    stroke(90);
    sb_q.push_back(mk(90, 1'b0, 1'b0, 0, 2));
    stroke(80);
    sb_q.push_back(mk(80, 1'b1, 1'b0, 1, 3));
    bus.sensor_in = 1'b1;
    cyc(10);
    bus.sensor_in = 1'b0;
    cyc(20);
    snap("pre_reset_drive", mks(1, 80, 3));
    cyc(2);

    // Reset mid-DRIVE clears every output on the next cycle.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    snap("mid_reset", mks(0, 0, 0));
    cyc(10);

    end_req = 1'b1;
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
